// File: rtl/pts_program_loader_if.sv
// Host byte link and PTS controller programming bus, bundled for the program loader.
interface pts_program_loader_if;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        oRxReady;
    logic        oSET_INDEX_FLAG;
    logic [7:0]  oSET_INDEX;
    logic        oSET_CODE_FLAG;
    logic [31:0] oSET_CODE;
    logic        oBusy;
    logic        oDone;
    logic        oError;
    logic [1:0]  oErrCode;
    logic [7:0]  oFrameCount;

    modport master (
        output iRxData, iRxValid,
        input  oRxReady, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE,
               oBusy, oDone, oError, oErrCode, oFrameCount
    );

    modport slave (
        input  iRxData, iRxValid,
        output oRxReady, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE,
               oBusy, oDone, oError, oErrCode, oFrameCount
    );
endinterface

// File: rtl/pts_program_loader.sv
// Parses framed host commands and drives the PTS controller index/code strobes
// with programmable setup, pulse and hold timing.
module pts_program_loader #(
    parameter int unsigned MAX_PULSE   = 8,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                 iClk,
    input  logic                 iRst,
    pts_program_loader_if.slave  bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = 16;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SEL   = 8'h02;

    typedef enum logic [3:0] {
        IDLE, RECV, CHECK, IDX_SETUP, IDX_PULSE, IDX_HOLD,
        CODE_SETUP, CODE_PULSE, CODE_HOLD, DONE
    } state_t;

    state_t            state;
    logic [2:0]        byte_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]  tcnt;
    logic [55:0]       frame_sr;   // CMD, IDX, C3..C0, CHK once seven bytes are in

    logic       accept_c;
    logic [7:0] cmd_c;
    logic [7:0] idx_c;
    logic       chk_ok_c;
    logic       cmd_ok_c;
    logic       idx_ok_c;

    assign accept_c = bus.iRxValid && bus.oRxReady;
    assign cmd_c    = frame_sr[55:48];
    assign idx_c    = frame_sr[47:40];
    assign chk_ok_c = (frame_sr[55:48] ^ frame_sr[47:40] ^ frame_sr[39:32] ^ frame_sr[31:24]
                     ^ frame_sr[23:16] ^ frame_sr[15:8] ^ frame_sr[7:0]) == 8'h00;
    assign cmd_ok_c = (cmd_c == CMD_WRITE) || (cmd_c == CMD_SEL);
    assign idx_ok_c = 32'(idx_c) < MAX_PULSE;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state               <= IDLE;
            byte_cnt            <= 3'd0;
            idle_cnt            <= '0;
            tcnt                <= '0;
            frame_sr            <= '0;
            bus.oRxReady        <= 1'b0;
            bus.oSET_INDEX_FLAG <= 1'b0;
            bus.oSET_INDEX      <= 8'h00;
            bus.oSET_CODE_FLAG  <= 1'b0;
            bus.oSET_CODE       <= 32'h0;
            bus.oBusy           <= 1'b0;
            bus.oDone           <= 1'b0;
            bus.oError          <= 1'b0;
            bus.oErrCode        <= 2'd0;
            bus.oFrameCount     <= 8'h00;
        end else begin
            bus.oDone  <= 1'b0;
            bus.oError <= 1'b0;
            case (state)
                IDLE: begin
                    bus.oRxReady <= 1'b1;
                    if (accept_c && bus.iRxData == SYNC) begin
                        state     <= RECV;
                        bus.oBusy <= 1'b1;
                        byte_cnt  <= 3'd0;
                        idle_cnt  <= '0;
                    end
                end
                RECV: begin
                    if (accept_c) begin
                        frame_sr <= {frame_sr[47:0], bus.iRxData};
                        idle_cnt <= '0;
                        if (byte_cnt == 3'd6) begin
                            state        <= CHECK;
                            bus.oRxReady <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        state        <= IDLE;
                        bus.oBusy    <= 1'b0;
                        bus.oError   <= 1'b1;
                        bus.oErrCode <= 2'd0;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    if (!chk_ok_c || !cmd_ok_c || !idx_ok_c) begin
                        state        <= IDLE;
                        bus.oRxReady <= 1'b1;
                        bus.oBusy    <= 1'b0;
                        bus.oError   <= 1'b1;
                        bus.oErrCode <= !chk_ok_c ? 2'd1 : (!cmd_ok_c ? 2'd2 : 2'd3);
                    end else begin
                        state          <= IDX_SETUP;
                        tcnt           <= CNT_W'(SETUP_CYC - 1);
                        bus.oSET_INDEX <= idx_c;
                        if (cmd_c == CMD_WRITE) bus.oSET_CODE <= frame_sr[39:8];
                    end
                end
                IDX_SETUP: begin
                    if (tcnt == '0) begin
                        state               <= IDX_PULSE;
                        tcnt                <= CNT_W'(PULSE_CYC - 1);
                        bus.oSET_INDEX_FLAG <= 1'b1;
                    end else tcnt <= tcnt - CNT_W'(1);
                end
                IDX_PULSE: begin
                    if (tcnt == '0) begin
                        state               <= IDX_HOLD;
                        tcnt                <= CNT_W'(HOLD_CYC - 1);
                        bus.oSET_INDEX_FLAG <= 1'b0;
                    end else tcnt <= tcnt - CNT_W'(1);
                end
                IDX_HOLD: begin
                    if (tcnt != '0) begin
                        tcnt <= tcnt - CNT_W'(1);
                    end else if (cmd_c == CMD_WRITE) begin
                        state <= CODE_SETUP;
                        tcnt  <= CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state           <= DONE;
                        bus.oDone       <= 1'b1;
                        bus.oFrameCount <= bus.oFrameCount + 8'd1;
                        bus.oRxReady    <= 1'b1;
                        bus.oBusy       <= 1'b0;
                    end
                end
                CODE_SETUP: begin
                    if (tcnt == '0) begin
                        state              <= CODE_PULSE;
                        tcnt               <= CNT_W'(PULSE_CYC - 1);
                        bus.oSET_CODE_FLAG <= 1'b1;
                    end else tcnt <= tcnt - CNT_W'(1);
                end
                CODE_PULSE: begin
                    if (tcnt == '0) begin
                        state              <= CODE_HOLD;
                        tcnt               <= CNT_W'(HOLD_CYC - 1);
                        bus.oSET_CODE_FLAG <= 1'b0;
                    end else tcnt <= tcnt - CNT_W'(1);
                end
                CODE_HOLD: begin
                    if (tcnt == '0) begin
                        state           <= DONE;
                        bus.oDone       <= 1'b1;
                        bus.oFrameCount <= bus.oFrameCount + 8'd1;
                        bus.oRxReady    <= 1'b1;
                        bus.oBusy       <= 1'b0;
                    end else tcnt <= tcnt - CNT_W'(1);
                end
                DONE: begin
                    // A SYNC arriving back-to-back with completion starts the next frame.
                    if (accept_c && bus.iRxData == SYNC) begin
                        state     <= RECV;
                        bus.oBusy <= 1'b1;
                        byte_cnt  <= 3'd0;
                        idle_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pts_program_loader.sv
// Directed bench for pts_program_loader: strobe timing, errors, timeout, reset and frame-count wrap.
module tb_pts_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0]  idx_e1;
    logic [31:0] code_e1;
    logic [31:0] itr, ctr, dtr, etr;

    pts_program_loader_if bus ();

    pts_program_loader #(.TIMEOUT_CYC(1000)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive a byte and hold it until the edge that accepts it; returns #1 after that edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.iRxValid = 1'b1;
        bus.iRxData  = b;
        while (!bus.oRxReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.iRxValid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8]);
    endtask

    // Bit k of each trace holds the output sampled just after edge E(k) following CHK.
    task automatic trace(input int n);
        itr = '0; ctr = '0; dtr = '0; etr = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            itr[k] = bus.oSET_INDEX_FLAG;
            ctr[k] = bus.oSET_CODE_FLAG;
            dtr[k] = bus.oDone;
            etr[k] = bus.oError;
            if (k == 1) begin
                idx_e1  = bus.oSET_INDEX;
                code_e1 = bus.oSET_CODE;
            end
        end
    endtask

    localparam logic [63:0] F_WRITE   = 64'hA5_01_03_12_34_56_78_0A;
    localparam logic [63:0] F_SEL     = 64'hA5_02_05_00_00_00_00_07;
    localparam logic [63:0] F_BADCHK  = 64'hA5_01_03_12_34_56_78_0B;
    localparam logic [63:0] F_BADIDX  = 64'hA5_01_08_00_00_00_00_09;
    localparam logic [63:0] F_BADCMD  = 64'hA5_07_00_00_00_00_00_07;

    initial begin
        int n;
        bus.iRxValid = 1'b0;
        bus.iRxData  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {27'd0, bus.oRxReady, bus.oSET_INDEX_FLAG, bus.oSET_CODE_FLAG,
                          bus.oBusy, bus.oDone}, 32'd0);
        check("rst_err", {29'd0, bus.oError, bus.oErrCode}, 32'd0);
        check("rst_index", {24'd0, bus.oSET_INDEX}, 32'd0);
        check("rst_code", bus.oSET_CODE, 32'd0);
        check("rst_count", {24'd0, bus.oFrameCount}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", {31'd0, bus.oRxReady}, 32'd1);

        // 1: WRITE frame
        send_frame(F_WRITE);
        check("t1_busy_e0", {31'd0, bus.oBusy}, 32'd1);
        trace(15);
        check("t1_index_e1", {24'd0, idx_e1}, 32'h03);
        check("t1_code_e1", code_e1, 32'h12345678);
        check("t1_idx_flag", itr, 32'h0000_0018);
        check("t1_code_flag", ctr, 32'h0000_0600);
        check("t1_done", dtr, 32'h0000_2000);
        check("t1_err", etr, 32'd0);
        check("t1_count", {24'd0, bus.oFrameCount}, 32'd1);
        check("t1_busy_end", {31'd0, bus.oBusy}, 32'd0);

        // 2: SEL frame
        send_frame(F_SEL);
        trace(10);
        check("t2_index_e1", {24'd0, idx_e1}, 32'h05);
        check("t2_code_kept", code_e1, 32'h12345678);
        check("t2_idx_flag", itr, 32'h0000_0018);
        check("t2_code_flag", ctr, 32'd0);
        check("t2_done", dtr, 32'h0000_0080);
        check("t2_count", {24'd0, bus.oFrameCount}, 32'd2);

        // 3: bad checksum, then a good frame
        send_frame(F_BADCHK);
        trace(6);
        check("t3_err", etr, 32'h0000_0002);
        check("t3_flags", itr | ctr | dtr, 32'd0);
        check("t3_errcode", {30'd0, bus.oErrCode}, 32'd1);
        check("t3_index_kept", {24'd0, bus.oSET_INDEX}, 32'h05);
        send_frame(F_WRITE);
        trace(15);
        check("t3_idx_flag", itr, 32'h0000_0018);
        check("t3_code_flag", ctr, 32'h0000_0600);
        check("t3_done", dtr, 32'h0000_2000);
        check("t3_count", {24'd0, bus.oFrameCount}, 32'd3);

        // 4: index range and bad command
        send_frame(F_BADIDX);
        trace(4);
        check("t4_idx_err", etr, 32'h0000_0002);
        check("t4_idx_errcode", {30'd0, bus.oErrCode}, 32'd3);
        send_frame(F_BADCMD);
        trace(4);
        check("t4_cmd_err", etr | itr, 32'h0000_0002);
        check("t4_cmd_errcode", {30'd0, bus.oErrCode}, 32'd2);

        // 5: timeout mid-frame, then junk before a valid frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        n = 0;
        while (!bus.oError && n < 1100) begin
            @(posedge clk);
            #1 n++;
        end
        check("t5_timeout_lat", 32'(n), 32'd1000);
        check("t5_errcode", {30'd0, bus.oErrCode}, 32'd0);
        check("t5_busy", {31'd0, bus.oBusy}, 32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("t5_junk_busy", {31'd0, bus.oBusy}, 32'd0);
        send_frame(F_WRITE);
        trace(15);
        check("t5_done", dtr, 32'h0000_2000);
        check("t5_count", {24'd0, bus.oFrameCount}, 32'd4);

        // 6: reset during CODE_PULSE
        send_frame(F_WRITE);
        trace(9);
        check("t6_code_high", {31'd0, bus.oSET_CODE_FLAG}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_flags", {30'd0, bus.oSET_CODE_FLAG, bus.oSET_INDEX_FLAG}, 32'd0);
        check("t6_rst_ctl", {29'd0, bus.oRxReady, bus.oBusy, bus.oDone}, 32'd0);
        check("t6_rst_data", {bus.oSET_INDEX, bus.oFrameCount, 14'd0, bus.oErrCode}, 32'd0);
        check("t6_rst_code", bus.oSET_CODE, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(F_WRITE);
        trace(15);
        check("t6_idx_flag", itr, 32'h0000_0018);
        check("t6_code_flag", ctr, 32'h0000_0600);
        check("t6_done", dtr, 32'h0000_2000);
        check("t6_count", {24'd0, bus.oFrameCount}, 32'd1);

        // Frame-count wrap: 255 more frames after the one above
        for (int f = 0; f < 255; f++) begin
            send_frame(F_SEL);
            n = 0;
            while (!bus.oDone && n < 40) begin
                @(posedge clk);
                #1 n++;
            end
            if (n >= 40) check("wrap_done_wait", 32'd0, 32'd1);
            if (f == 253) check("wrap_count_255", {24'd0, bus.oFrameCount}, 32'd255);
        end
        check("wrap_count_0", {24'd0, bus.oFrameCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pts_program_loader.md
Name: pts_program_loader

Overview:
Host-side programming engine for the 32-channel PTS pulse-table controller. It parses framed byte commands from the host link (UART/USB byte stream with valid/ready handshake) and emits the controller's programming interface. That interface is an index strobe, a code strobe, and their data buses, with programmable setup, pulse and hold timing. The timing matters because the controller uses both flags as edge clocks. The block sits between the host byte receiver and the controller's iSET_INDEX_FLAG, iSET_INDEX, iSET_CODE_FLAG and iSET_CODE inputs.

Parameters:
MAX_PULSE, 8, number of table entries; frame index must be < MAX_PULSE
SETUP_CYC, 2, cycles data is stable before a flag rises (>=1)
PULSE_CYC, 2, cycles a flag is held high (>=1)
HOLD_CYC, 2, cycles data is held stable after a flag falls (>=1)
TIMEOUT_CYC, 50000, max idle cycles between bytes inside a frame (16-bit counter)

Ports:
iClk  input  1  system clock
iRst  input  1  reset
iRxData  input  8  host byte
iRxValid  input  1  iRxData valid
oRxReady  output  1  byte accepted when iRxValid && oRxReady
oSET_INDEX_FLAG  output  1  index strobe to controller
oSET_INDEX  output  8  index to controller
oSET_CODE_FLAG  output  1  code strobe to controller
oSET_CODE  output  32  code to controller
oBusy  output  1  frame in progress (RECV through HOLD states)
oDone  output  1  1-cycle pulse on frame completion
oError  output  1  1-cycle pulse on frame abort
oErrCode  output  2  last error: 0 timeout, 1 checksum, 2 bad cmd, 3 index range
oFrameCount  output  8  completed-frame counter, wraps 255->0

Behaviour:
- One clock, iClk. iRst is synchronous and active-high.
- Reset values: all outputs 0. oRxReady rises the first cycle after iRst deasserts.
- Reset mid-operation: flags drop to 0 on the next edge. A truncated strobe at the controller is accepted.
- Frame format, 8 bytes: SYNC=0xA5, CMD, IDX, C3, C2, C1, C0 (MSB first), CHK.
- CHK = XOR of CMD, IDX, C3, C2, C1 and C0.
- CMD 0x01 WRITE: index strobe, then code strobe.
- CMD 0x02 SEL: index strobe only. Code bytes are required but ignored.
- FSM states: IDLE, RECV, CHECK, IDX_SETUP, IDX_PULSE, IDX_HOLD, CODE_SETUP, CODE_PULSE, CODE_HOLD, DONE.
- IDLE: oRxReady=1. Non-0xA5 bytes are discarded. 0xA5 goes to RECV.
- RECV: oRxReady=1. Collects 7 bytes. A 0xA5 inside a frame is data; there is no resync.
- RECV timeout: if TIMEOUT_CYC consecutive cycles pass with no accepted byte, pulse oError, set oErrCode=0, go to IDLE.
- CHECK (1 cycle, oRxReady=0): error priority is checksum(1) > cmd not 0x01/0x02 (2) > IDX >= MAX_PULSE (3).
- On error: oError pulse, oErrCode updated, go to IDLE. Controller outputs untouched.
- Timing reference: E0 is the edge accepting CHK.
- oSET_INDEX and oSET_CODE are loaded at E1 and held stable until the next frame loads them.
- oSET_INDEX_FLAG is high for PULSE_CYC cycles starting at E1+SETUP_CYC.
- HOLD_CYC cycles follow the index flag falling.
- WRITE only: CODE_SETUP (SETUP_CYC cycles), then oSET_CODE_FLAG high PULSE_CYC cycles, then HOLD_CYC cycles.
- The index strobe always fully completes (flag low, hold elapsed) before the code flag rises. The controller latches its index on the falling index flag.
- DONE (1 cycle): oDone=1, oFrameCount+1, oRxReady=1; a SYNC byte may be accepted this cycle.
- Latency with defaults:
  - WRITE: index flag high E3–E4, code flag high E9–E10, oDone at E13.
  - SEL: oDone at E7.
- oRxReady=0 from CHECK through CODE_HOLD; iRxValid is ignored there.
- Flags are never both high. Each flag is registered and glitch-free.
- oBusy=1 in RECV through CODE_HOLD, 0 in IDLE and DONE.

Test Plan:
1. Reset, then send A5 01 03 12 34 56 78 0A -> oSET_INDEX=0x03 and oSET_CODE=0x12345678 from E1; index flag high E3–E4; code flag high E9–E10; oDone at E13; oFrameCount=1.
2. Send A5 02 05 00 00 00 00 07 -> single index strobe E3–E4 with oSET_INDEX=0x05, no code flag, oDone at E7.
3. Send A5 01 03 12 34 56 78 0B -> oError, oErrCode=1, no flags. Then the frame from test 1 succeeds.
4. Send A5 01 08 00 00 00 00 09 -> oErrCode=3. Send A5 07 00 00 00 00 00 07 -> oErrCode=2.
5. Send A5 01 03, then idle TIMEOUT_CYC cycles -> oError, oErrCode=0, back in IDLE. Junk bytes 0x11 0x22 before a valid frame are discarded.
6. Assert iRst during CODE_PULSE -> code flag low next edge, all outputs 0; next valid frame completes normally. Also send 256 frames -> oFrameCount wraps to 0.
